npu_dma_engine: RTL and testbench

NPU_DMA_ENGINE -- requirements
Module: npu_dma_engine

---
 rtl/npu_dma_engine.sv | 165 ++++++++++++++++
 tb/tb_npu_dma_engine.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_dma_engine.sv
// npu_dma_engine: single-channel DMA moving 128-bit beats between host memory and local SRAM.
// Define NPU_DMA_TIMEOUT_EN to abort a transfer whose host handshake stalls for TIMEOUT_CYC cycles.
module npu_dma_engine #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dma_req,
  output logic         dma_ready,
  input  logic         dma_rwn,
  input  logic [39:0]  dma_hostAddr,
  input  logic [15:0]  dma_localAddr,
  input  logic [15:0]  dma_transferLength,
  output logic         dma_ack,
  output logic         dma_err,
  output logic         host_rd_req,
  output logic [39:0]  host_rd_addr,
  input  logic         host_rd_rdy,
  input  logic         host_rd_vld,
  input  logic [127:0] host_rd_data,
  output logic         host_wr_vld,
  output logic [39:0]  host_wr_addr,
  output logic [127:0] host_wr_data,
  input  logic         host_wr_rdy,
  output logic         sram_ena,
  output logic         sram_wea,
  output logic [11:0]  sram_addra,
  output logic [127:0] sram_dina,
  output logic         sram_enb,
  output logic [11:0]  sram_addrb,
  input  logic [127:0] sram_doutb
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_FETCH, WR_CAPT, WR_SEND, DONE
  } state_t;

  state_t      state;
  logic [39:0] host_addr;
  logic [11:0] local_word;
  logic [11:0] beats;
  logic        last_beat;
  logic        rd_beat;
  logic        abort;

  assign last_beat = (beats == 12'd1);
  // SRAM write happens in the same cycle the host data beat arrives.
  assign rd_beat   = (state == RD_DATA) && host_rd_vld;

  assign dma_ready    = (state == IDLE);
  assign dma_ack      = (state == DONE);
  assign host_rd_req  = (state == RD_ADDR);
  assign host_rd_addr = host_addr;
  assign host_wr_vld  = (state == WR_SEND);
  assign host_wr_addr = host_addr;
  assign sram_ena     = rd_beat;
  assign sram_wea     = rd_beat;
  assign sram_addra   = local_word;
  assign sram_dina    = rd_beat ? host_rd_data : '0;
  assign sram_enb     = (state == WR_FETCH);
  assign sram_addrb   = local_word;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      host_addr    <= '0;
      local_word   <= '0;
      beats        <= '0;
      host_wr_data <= '0;
    end else begin
      case (state)
        IDLE: if (dma_req) begin
          host_addr  <= {dma_hostAddr[39:4], 4'h0};
          local_word <= dma_localAddr[15:4];
          beats      <= dma_transferLength[15:4];
          if (dma_transferLength[15:4] == 12'd0) state <= DONE;
          else if (dma_rwn)                      state <= RD_ADDR;
          else                                   state <= WR_FETCH;
        end
        RD_ADDR: begin
          if (host_rd_rdy) state <= RD_DATA;
          else if (abort)  state <= DONE;
        end
        RD_DATA: begin
          if (host_rd_vld) begin
            host_addr  <= host_addr + 40'd16;
            local_word <= local_word + 12'd1;
            beats      <= beats - 12'd1;
            state      <= last_beat ? DONE : RD_ADDR;
          end else if (abort) begin
            state <= DONE;
          end
        end
        WR_FETCH: state <= WR_CAPT;
        WR_CAPT: begin
          host_wr_data <= sram_doutb;
          state        <= WR_SEND;
        end
        WR_SEND: begin
          if (host_wr_rdy) begin
            host_addr  <= host_addr + 40'd16;
            local_word <= local_word + 12'd1;
            beats      <= beats - 12'd1;
            state      <= last_beat ? DONE : WR_FETCH;
          end else if (abort) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NPU_DMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] tcnt;
  logic          tmo;
  logic          leave;
  logic          err_q;

  assign tmo   = (tcnt == CW'(TIMEOUT_CYC - 1));
  assign abort = tmo && (((state == RD_ADDR) && !host_rd_rdy) ||
                         ((state == RD_DATA) && !host_rd_vld) ||
                         ((state == WR_SEND) && !host_wr_rdy));

  // Mirrors the FSM's exit conditions so the watchdog restarts on every state entry.
  always_comb begin
    leave = 1'b1;
    case (state)
      IDLE:    leave = dma_req;
      RD_ADDR: leave = host_rd_rdy || abort;
      RD_DATA: leave = host_rd_vld || abort;
      WR_SEND: leave = host_wr_rdy || abort;
      default: leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= leave ? '0 : tcnt + 1'b1;
      if (abort)               err_q <= 1'b1;
      else if (state == IDLE)  err_q <= 1'b0;
    end
  end

  assign dma_err = (state == DONE) && err_q;

  logic unused_ok;
  assign unused_ok = ^{dma_hostAddr[3:0], dma_localAddr[3:0], dma_transferLength[3:0]};
`else
  assign abort   = 1'b0;
  assign dma_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{dma_hostAddr[3:0], dma_localAddr[3:0], dma_transferLength[3:0],
                       (TIMEOUT_CYC != 0)};
`endif

endmodule

// File: tb/tb_npu_dma_engine.sv
// Directed bench for npu_dma_engine with behavioural host and SRAM responders.
// Build with NPU_DMA_TIMEOUT_EN defined to exercise the stall-abort path instead of the wait path.
module tb_npu_dma_engine;

`ifdef NPU_DMA_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dma_req = 1'b0;
  logic         dma_rwn = 1'b0;
  logic [39:0]  dma_hostAddr = '0;
  logic [15:0]  dma_localAddr = '0;
  logic [15:0]  dma_transferLength = '0;
  logic         dma_ready, dma_ack, dma_err;
  logic         host_rd_req, host_rd_rdy;
  logic [39:0]  host_rd_addr;
  logic         host_rd_vld = 1'b0;
  logic [127:0] host_rd_data = '0;
  logic         host_wr_vld;
  logic [39:0]  host_wr_addr;
  logic [127:0] host_wr_data;
  logic         host_wr_rdy = 1'b0;
  logic         sram_ena, sram_wea, sram_enb;
  logic [11:0]  sram_addra, sram_addrb;
  logic [127:0] sram_dina;
  logic [127:0] sram_doutb = '0;

  always #5 clk = ~clk;

  npu_dma_engine #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .dma_req(dma_req), .dma_ready(dma_ready), .dma_rwn(dma_rwn),
    .dma_hostAddr(dma_hostAddr), .dma_localAddr(dma_localAddr),
    .dma_transferLength(dma_transferLength), .dma_ack(dma_ack), .dma_err(dma_err),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_rdy(host_rd_rdy),
    .host_rd_vld(host_rd_vld), .host_rd_data(host_rd_data),
    .host_wr_vld(host_wr_vld), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_rdy(host_wr_rdy),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_addra(sram_addra), .sram_dina(sram_dina),
    .sram_enb(sram_enb), .sram_addrb(sram_addrb), .sram_doutb(sram_doutb)
  );

  int errors = 0;
  int checks = 0;

  logic         rd_rdy_en = 1'b1;
  int           wr_stall = 0;
  logic         pre_en = 1'b0;
  logic [11:0]  pre_addr = '0;
  logic [127:0] pre_data = '0;
  assign host_rd_rdy = rd_rdy_en;

  logic [127:0] mem [4096];
  int ack_count = 0, err_count = 0, strobe_cycles = 0, stall_cycles = 0, hold_viol = 0, wr_wait = 0;
  logic         hold_pend = 1'b0;
  logic [39:0]  p_waddr = '0, p_raddr = '0;
  logic [127:0] p_wdata = '0;
  logic [11:0]  sw_addr_q[$];
  logic [127:0] sw_data_q[$];
  logic [39:0]  hr_addr_q[$];
  logic [39:0]  hw_addr_q[$];
  logic [127:0] hw_data_q[$];

  function automatic logic [127:0] rd_pat(input logic [39:0] a);
    return {24'hDA7A00, a, 64'h0123_4567_89AB_CDEF};
  endfunction

  // Host and SRAM responders plus event monitors.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (sram_ena && sram_wea) begin
      mem[sram_addra] <= sram_dina;
      sw_addr_q.push_back(sram_addra);
      sw_data_q.push_back(sram_dina);
    end
    if (sram_enb) sram_doutb <= mem[sram_addrb];
    host_rd_vld <= 1'b0;
    if (host_rd_req && host_rd_rdy) begin
      host_rd_vld  <= 1'b1;
      host_rd_data <= rd_pat(host_rd_addr);
      hr_addr_q.push_back(host_rd_addr);
    end
    if (host_wr_vld && host_wr_rdy) begin
      hw_addr_q.push_back(host_wr_addr);
      hw_data_q.push_back(host_wr_data);
      host_wr_rdy <= 1'b0;
      wr_wait     <= 0;
    end else if (host_wr_vld) begin
      stall_cycles <= stall_cycles + 1;
      if (wr_wait >= wr_stall) host_wr_rdy <= 1'b1;
      else                     wr_wait <= wr_wait + 1;
    end
    if (dma_ack) begin
      ack_count <= ack_count + 1;
      if (dma_err) err_count <= err_count + 1;
    end
    if (host_rd_req || host_wr_vld || sram_ena || sram_wea || sram_enb)
      strobe_cycles <= strobe_cycles + 1;
    if (hold_pend && ((host_wr_vld && (host_wr_addr !== p_waddr || host_wr_data !== p_wdata)) ||
                      (host_rd_req && host_rd_addr !== p_raddr)))
      hold_viol <= hold_viol + 1;
    hold_pend <= (host_wr_vld && !host_wr_rdy) || (host_rd_req && !host_rd_rdy);
    p_waddr   <= host_wr_addr;
    p_wdata   <= host_wr_data;
    p_raddr   <= host_rd_addr;
  end

  task automatic start(input logic rwn, input logic [39:0] ha, input logic [15:0] la,
                       input logic [15:0] len);
    @(negedge clk);
    dma_rwn = rwn; dma_hostAddr = ha; dma_localAddr = la; dma_transferLength = len;
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    while (dma_ack !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [127:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dma_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", dma_ready);
    end
    checks++;
    if ({host_rd_req, host_wr_vld, sram_ena, sram_wea, sram_enb, dma_ack, dma_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {host_rd_req, host_wr_vld, sram_ena, sram_wea, sram_enb, dma_ack, dma_err});
    end
    checks++;
    if ({host_rd_addr, host_wr_addr, host_wr_data, sram_addra, sram_addrb, sram_dina} !== '0) begin
      errors++;
      $display("FAIL reset_buses: rd_addr=%h wr_addr=%h wr_data=%h addra=%h addrb=%h dina=%h expected all 0",
               host_rd_addr, host_wr_addr, host_wr_data, sram_addra, sram_addrb, sram_dina);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dma_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b expected 1", dma_ready);
    end
  endtask

  task automatic test_read();
    int b0, r0, a0, e0, cyc;
    b0 = sw_addr_q.size(); r0 = hr_addr_q.size(); a0 = ack_count; e0 = err_count;
    start(1'b1, 40'h100, 16'h0020, 16'd64);
    checks++;
    if (dma_ready !== 1'b0) begin
      errors++; $display("FAIL read_busy_ready: got %b expected 0", dma_ready);
    end
    wait_ack(100, cyc);
    checks++;
    if (cyc >= 100) begin
      errors++; $display("FAIL read_ack_timeout: waited %0d cycles, required ack", cyc);
    end
    @(negedge clk);
    checks++;
    if (ack_count - a0 != 1 || err_count - e0 != 0) begin
      errors++; $display("FAIL read_ack: acks=%0d errs=%0d expected 1/0", ack_count - a0, err_count - e0);
    end
    checks++;
    if (sw_addr_q.size() - b0 != 4 || hr_addr_q.size() - r0 != 4) begin
      errors++;
      $display("FAIL read_beats: sram=%0d host=%0d expected 4/4", sw_addr_q.size() - b0, hr_addr_q.size() - r0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sw_addr_q[b0+i] !== 12'(2 + i) || sw_data_q[b0+i] !== rd_pat(40'h100 + 40'(16 * i)) ||
            hr_addr_q[r0+i] !== 40'h100 + 40'(16 * i)) begin
          errors++;
          $display("FAIL read_beat%0d: word=%0d host=%h data=%h expected word=%0d host=%h",
                   i, sw_addr_q[b0+i], hr_addr_q[r0+i], sw_data_q[b0+i], 2 + i, 40'h100 + 40'(16 * i));
        end
      end
    end
  endtask

  task automatic test_write();
    int h0, a0, s0, v0, cyc;
    preload(12'd0, 128'hAAAA_0000_1111_2222_3333_4444_5555_6666);
    preload(12'd1, 128'h5555_7777_8888_9999_AAAA_BBBB_CCCC_DDDD);
    wr_stall = 5;
    h0 = hw_addr_q.size(); a0 = ack_count; s0 = stall_cycles; v0 = hold_viol;
    start(1'b0, 40'h0, 16'h0000, 16'd32);
    wait_ack(200, cyc);
    checks++;
    if (cyc >= 200) begin
      errors++; $display("FAIL write_ack_timeout: waited %0d cycles, required ack", cyc);
    end
    checks++;
    if (dma_err !== 1'b0) begin
      errors++; $display("FAIL write_err: got %b expected 0", dma_err);
    end
    @(negedge clk);
    wr_stall = 0;
    checks++;
    if (ack_count - a0 != 1) begin
      errors++; $display("FAIL write_ack_count: got %0d expected 1", ack_count - a0);
    end
    checks++;
    if (stall_cycles - s0 < 10 || hold_viol != v0) begin
      errors++;
      $display("FAIL write_stall_hold: stalled=%0d viol=%0d expected >=10 stalled, 0 viol",
               stall_cycles - s0, hold_viol - v0);
    end
    checks++;
    if (hw_addr_q.size() - h0 != 2) begin
      errors++; $display("FAIL write_beats: got %0d expected 2", hw_addr_q.size() - h0);
    end else begin
      checks++;
      if (hw_addr_q[h0] !== 40'h0 || hw_data_q[h0] !== 128'hAAAA_0000_1111_2222_3333_4444_5555_6666) begin
        errors++; $display("FAIL write_beat0: addr=%h data=%h expected 0 / word0", hw_addr_q[h0], hw_data_q[h0]);
      end
      checks++;
      if (hw_addr_q[h0+1] !== 40'h10 || hw_data_q[h0+1] !== 128'h5555_7777_8888_9999_AAAA_BBBB_CCCC_DDDD) begin
        errors++;
        $display("FAIL write_beat1: addr=%h data=%h expected 10 / word1", hw_addr_q[h0+1], hw_data_q[h0+1]);
      end
    end
  endtask

  task automatic test_zero_len();
    int s0, r0;
    s0 = strobe_cycles; r0 = hr_addr_q.size();
    start(1'b1, 40'h4000, 16'h0040, 16'h000F);
    checks++;
    if (dma_ack !== 1'b1 || dma_err !== 1'b0) begin
      errors++; $display("FAIL zero_ack: ack=%b err=%b expected 1/0", dma_ack, dma_err);
    end
    @(negedge clk);
    checks++;
    if (dma_ack !== 1'b0 || dma_ready !== 1'b1) begin
      errors++; $display("FAIL zero_return: ack=%b ready=%b expected 0/1", dma_ack, dma_ready);
    end
    checks++;
    if (strobe_cycles != s0 || hr_addr_q.size() != r0) begin
      errors++; $display("FAIL zero_strobes: strobe cycles=%0d expected 0", strobe_cycles - s0);
    end
  endtask

  task automatic test_wrap();
    int b0, cyc;
    b0 = sw_addr_q.size();
    start(1'b1, 40'hFF_FFFF_FFF0, 16'hFFF0, 16'd32);
    wait_ack(100, cyc);
    @(negedge clk);
    checks++;
    if (cyc >= 100 || sw_addr_q.size() - b0 != 2) begin
      errors++; $display("FAIL wrap_beats: cyc=%0d writes=%0d expected ack and 2", cyc, sw_addr_q.size() - b0);
    end else begin
      checks++;
      if (sw_addr_q[b0] !== 12'd4095 || sw_data_q[b0] !== rd_pat(40'hFF_FFFF_FFF0)) begin
        errors++; $display("FAIL wrap_beat0: word=%0d data=%h expected 4095", sw_addr_q[b0], sw_data_q[b0]);
      end
      checks++;
      if (sw_addr_q[b0+1] !== 12'd0 || sw_data_q[b0+1] !== rd_pat(40'h0)) begin
        errors++; $display("FAIL wrap_beat1: word=%0d data=%h expected 0 / host 0", sw_addr_q[b0+1], sw_data_q[b0+1]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int b0, a0, h0, cyc;
    b0 = sw_addr_q.size(); a0 = ack_count; h0 = hw_addr_q.size();
    start(1'b1, 40'h600, 16'h0300, 16'd48);
    dma_rwn = 1'b0; dma_hostAddr = 40'h9000; dma_localAddr = 16'h0; dma_transferLength = 16'h0100;
    dma_req = 1'b1;
    checks++;
    if (dma_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready: got %b expected 0", dma_ready);
    end
    repeat (3) @(negedge clk);
    dma_req = 1'b0;
    wait_ack(100, cyc);
    repeat (20) @(negedge clk);
    checks++;
    if (ack_count - a0 != 1 || sw_addr_q.size() - b0 != 3 || hw_addr_q.size() != h0) begin
      errors++;
      $display("FAIL busy_ignore: acks=%0d sram=%0d hostwr=%0d expected 1/3/0",
               ack_count - a0, sw_addr_q.size() - b0, hw_addr_q.size() - h0);
    end
  endtask

`ifdef NPU_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int b0, r0, cyc;
    b0 = sw_addr_q.size(); r0 = hr_addr_q.size();
    rd_rdy_en = 1'b0;
    start(1'b1, 40'h500, 16'h0080, 16'd16);
    cyc = 1;
    while (dma_ack !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 17 || dma_err !== 1'b1) begin
      errors++; $display("FAIL timeout_ack: at cycle %0d err=%b expected cycle 17 err=1", cyc, dma_err);
    end
    rd_rdy_en = 1'b1;
    @(negedge clk);
    checks++;
    if (sw_addr_q.size() != b0 || hr_addr_q.size() != r0 || dma_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clean: writes=%0d reads=%0d ready=%b expected 0/0/1",
               sw_addr_q.size() - b0, hr_addr_q.size() - r0, dma_ready);
    end
  endtask
`else
  task automatic test_rd_stall();
    int b0, a0, cyc;
    b0 = sw_addr_q.size(); a0 = ack_count;
    rd_rdy_en = 1'b0;
    start(1'b1, 40'h500, 16'h0080, 16'd16);
    repeat (40) @(negedge clk);
    checks++;
    if (ack_count != a0 || host_rd_req !== 1'b1 || host_rd_addr !== 40'h500 || dma_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: acks=%0d req=%b addr=%h ready=%b expected 0/1/500/0",
               ack_count - a0, host_rd_req, host_rd_addr, dma_ready);
    end
    rd_rdy_en = 1'b1;
    wait_ack(50, cyc);
    checks++;
    if (cyc >= 50 || dma_err !== 1'b0) begin
      errors++; $display("FAIL stall_finish: cyc=%0d err=%b expected ack with err=0", cyc, dma_err);
    end
    @(negedge clk);
    checks++;
    if (sw_addr_q.size() - b0 != 1 || sw_addr_q[sw_addr_q.size()-1] !== 12'h008) begin
      errors++; $display("FAIL stall_write: writes=%0d expected 1 at word 8", sw_addr_q.size() - b0);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int b0, a0, cyc;
    logic found;
    b0 = sw_addr_q.size(); a0 = ack_count; found = 1'b0;
    start(1'b1, 40'h1000, 16'h0000, 16'd128);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sram_ena === 1'b1 && sw_addr_q.size() - b0 >= 2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rstmid_reach: RD_DATA of beat 3 not seen, expected within 50 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dma_ready !== 1'b1 || {host_rd_req, sram_ena, dma_ack} !== 3'b0 || host_rd_addr !== 40'h0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%b req=%b ena=%b ack=%b addr=%h expected 1/0/0/0/0",
               dma_ready, host_rd_req, sram_ena, dma_ack, host_rd_addr);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ack_count != a0) begin
      errors++; $display("FAIL rstmid_noack: acks=%0d expected 0", ack_count - a0);
    end
    b0 = sw_addr_q.size();
    start(1'b1, 40'h2000, 16'h0100, 16'd16);
    wait_ack(50, cyc);
    checks++;
    if (cyc >= 50 || dma_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_next_ack: cyc=%0d err=%b expected ack err=0", cyc, dma_err);
    end
    @(negedge clk);
    checks++;
    if (sw_addr_q.size() - b0 != 1 || sw_addr_q[b0] !== 12'h010 || sw_data_q[b0] !== rd_pat(40'h2000)) begin
      errors++; $display("FAIL rstmid_next_write: writes=%0d expected 1 at word 0x010", sw_addr_q.size() - b0);
    end
    checks++;
    if (ack_count - a0 != 1) begin
      errors++; $display("FAIL rstmid_next_count: acks=%0d expected 1", ack_count - a0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_zero_len();
    test_wrap();
    test_busy_ignore();
`ifdef NPU_DMA_TIMEOUT_EN
    test_timeout();
`else
    test_rd_stall();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
